// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory subsystem
package dmem_pkg;

  // Default adr[31:16] value that selects the MMIO region
  localparam logic [15:0] MMIO_TAG_DFLT = 16'hFFFF;

  // MMIO register offsets (adr[7:0])
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESC    = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_CMP      = 8'h0C;
  localparam logic [7:0] OFF_STAT     = 8'h10;
  localparam logic [7:0] OFF_GPIO_OUT = 8'h14;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h18;

  // CTRL register bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - 32-bit timer with prescaler, compare match and level irq
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [7:0]       off_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             irq_o
);

  logic [2:0]       ctrl_q, ctrl_d;
  logic [15:0]      presc_q, presc_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             match_q, match_d;

  logic tick;
  logic hit;
  logic wr_ctrl, wr_presc, wr_count, wr_cmp, wr_stat;

  assign wr_ctrl  = we_i && (off_i == OFF_CTRL);
  assign wr_presc = we_i && (off_i == OFF_PRESC);
  assign wr_count = we_i && (off_i == OFF_COUNT);
  assign wr_cmp   = we_i && (off_i == OFF_CMP);
  assign wr_stat  = we_i && (off_i == OFF_STAT);

  // A tick fires on the cycle the prescaler reaches PRESC; a hit is a tick with COUNT==CMP
  assign tick = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
  assign hit  = tick && (count_q == cmp_q);

  // Level interrupt straight from registers, no extra pipeline stage
  assign irq_o = match_q & ctrl_q[CTRL_IRQEN];

  // Next-state logic; later assignments carry the higher priority
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    if (!ctrl_q[CTRL_EN] || tick) begin
      pcnt_d = 16'd0;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end

    if (tick) begin
      if (hit) begin
        if (ctrl_q[CTRL_AUTO]) begin
          count_d = '0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (wr_ctrl)  ctrl_d  = wdata_i[2:0];
    if (wr_presc) presc_d = wdata_i[15:0];
    if (wr_count) count_d = wdata_i;
    if (wr_cmp)   cmp_d   = wdata_i;

    if (wr_stat && wdata_i[0]) match_d = 1'b0;
    if (hit)                   match_d = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  // Register read mux; offsets not owned by the timer return 0
  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_CTRL:  rdata_o[2:0]  = ctrl_q;
      OFF_PRESC: rdata_o[15:0] = presc_q;
      OFF_COUNT: rdata_o       = count_q;
      OFF_CMP:   rdata_o       = cmp_q;
      OFF_STAT:  rdata_o[0]    = match_q;
      default:   rdata_o       = '0;
    endcase
  end

endmodule

// File: rtl/dmem_system.sv
// rtl/dmem_system.sv - data RAM plus memory-mapped timer and GPIO behind the core data port
module dmem_system
  import dmem_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          RAMBITS  = 8,
  parameter logic [15:0] MMIO_TAG = MMIO_TAG_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             irq,
  output logic [WIDTH-1:0] gpio_out,
  input  logic [WIDTH-1:0] gpio_in
);

  logic               mmio_sel;
  logic               ram_we;
  logic               mmio_we;
  logic [7:0]         off;
  logic [RAMBITS-1:0] ram_idx;
  logic [WIDTH-1:0]   timer_rdata;
  logic [WIDTH-1:0]   gpio_rdata;
  logic [WIDTH-1:0]   mmio_rdata;
  logic               unused_adr;

  logic [WIDTH-1:0] ram_q [0:(1<<RAMBITS)-1];
  logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [WIDTH-1:0] gpio_sync1_q, gpio_sync2_q;

  // Address decode: upper half-word picks MMIO, word index wraps into the RAM
  assign mmio_sel   = (adr[WIDTH-1 -: 16] == MMIO_TAG);
  assign off        = adr[7:0];
  assign ram_idx    = adr[RAMBITS+1:2];
  assign ram_we     = memwrite && !mmio_sel;
  assign mmio_we    = memwrite && mmio_sel;
  assign unused_adr = ^adr;

  // Data RAM write port, deliberately without reset
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= writedata;
  end

  dmem_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (mmio_we),
    .off_i   (off),
    .wdata_i (writedata),
    .rdata_o (timer_rdata),
    .irq_o   (irq)
  );

  // GPIO output register next state
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (mmio_we && (off == OFF_GPIO_OUT)) gpio_out_d = writedata;
  end

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q   <= '0;
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
    end else begin
      gpio_out_q   <= gpio_out_d;
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
    end
  end

  assign gpio_out = gpio_out_q;

  // GPIO read mux; non-GPIO offsets return 0 so it can be OR-merged with the timer
  always_comb begin
    gpio_rdata = '0;
    case (off)
      OFF_GPIO_OUT: gpio_rdata = gpio_out_q;
      OFF_GPIO_IN:  gpio_rdata = gpio_sync2_q;
      default:      gpio_rdata = '0;
    endcase
  end

  assign mmio_rdata = timer_rdata | gpio_rdata;

  // Combinational read port; shows the pre-write value during a simultaneous write
  always_comb begin
    memdata = '0;
    if (memread) begin
      memdata = mmio_sel ? mmio_rdata : ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_system.sv
// tb/tb_dmem_system.sv - directed scoreboard bench for dmem_system
module tb_dmem_system;

  localparam logic [31:0] A_CTRL     = 32'hFFFF_0000;
  localparam logic [31:0] A_PRESC    = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT    = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP      = 32'hFFFF_000C;
  localparam logic [31:0] A_STAT     = 32'hFFFF_0010;
  localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0014;
  localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0018;
  localparam logic [31:0] A_UNMAP    = 32'hFFFF_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] memdata;
  logic        irq;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  dmem_system #(
    .WIDTH   (32),
    .RAMBITS (8),
    .MMIO_TAG(16'hFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .irq       (irq),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in)
  );

  always #5 clk = ~clk;

  task automatic check_pop(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    check_pop(obs);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    adr = a; memread = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_pop(memdata);
    @(posedge clk); #1;
    memread = 1'b0;
  endtask

  task automatic rd_off(input logic [31:0] a, input string tag);
    adr = a; memread = 1'b0;
    exp_q.push_back(32'h0);
    tag_q.push_back(tag);
    @(negedge clk);
    check_pop(memdata);
    @(posedge clk); #1;
  endtask

  task automatic wr_rd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input string tag);
    adr = a; writedata = d; memwrite = 1'b1; memread = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_pop(memdata);
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0;
    adr = '0; writedata = '0; gpio_in = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_gpio_out", gpio_out, 32'h0);
    rd(A_CTRL,     32'h0, "reset_ctrl");
    rd(A_PRESC,    32'h0, "reset_presc");
    rd(A_COUNT,    32'h0, "reset_count");
    rd(A_STAT,     32'h0, "reset_stat");

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
    rd(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_lowbits_ignored");
    rd_off(32'h0000_0010, "ram_noread");
    wr_rd(32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, "ram_rw_prewrite");
    rd(32'h0000_0010, 32'h1234_5678, "ram_after_rw");

    wr(A_PRESC, 32'h0);
    wr(A_CMP,   32'h3);
    wr(A_CTRL,  32'h5);
    rd(A_COUNT, 32'h0, "oneshot_count0");
    rd(A_COUNT, 32'h1, "oneshot_count1");
    rd(A_COUNT, 32'h2, "oneshot_count2");
    rd(A_COUNT, 32'h3, "oneshot_count3");
    rd(A_STAT,  32'h1, "oneshot_match");
    chk("oneshot_irq", {31'b0, irq}, 32'h1);
    rd(A_COUNT, 32'h3, "oneshot_hold");
    rd(A_CTRL,  32'h4, "oneshot_en_cleared");
    wr(A_STAT,  32'h1);
    chk("oneshot_irq_cleared", {31'b0, irq}, 32'h0);
    rd(A_STAT,  32'h0, "oneshot_stat_cleared");

    wr(A_COUNT, 32'h0);
    wr(A_PRESC, 32'h2);
    wr(A_CMP,   32'h1);
    wr(A_CTRL,  32'h3);
    rd(A_COUNT, 32'h0, "auto_c0");
    rd(A_COUNT, 32'h0, "auto_c1");
    rd(A_COUNT, 32'h0, "auto_c2");
    rd(A_COUNT, 32'h1, "auto_c3");
    rd(A_COUNT, 32'h1, "auto_c4");
    rd(A_COUNT, 32'h1, "auto_c5");
    rd(A_STAT,  32'h1, "auto_match");
    chk("auto_irq_masked", {31'b0, irq}, 32'h0);
    wr(A_STAT,  32'h1);
    rd(A_STAT,  32'h0, "auto_w1c");
    rd(A_COUNT, 32'h1, "auto_reloaded_count");
    rd(A_STAT,  32'h0, "auto_before_match");
    wr(A_STAT,  32'h1);
    rd(A_STAT,  32'h1, "w1c_loses_to_match");
    rd(A_COUNT, 32'h0, "auto_second_reload");
    wr(A_COUNT, 32'h100);
    rd(A_COUNT, 32'h100, "count_write_beats_tick");
    wr(A_CTRL,  32'h0);

    wr(A_GPIO_OUT, 32'hA5);
    chk("gpio_out_pin", gpio_out, 32'hA5);
    rd(A_GPIO_OUT, 32'hA5, "gpio_out_read");
    gpio_in = 32'h3C;
    rd(A_GPIO_IN, 32'h0,  "gpio_in_edge0");
    rd(A_GPIO_IN, 32'h0,  "gpio_in_edge1");
    rd(A_GPIO_IN, 32'h3C, "gpio_in_edge2");
    wr(A_GPIO_IN, 32'h0);
    rd(A_GPIO_IN, 32'h3C, "gpio_in_readonly");
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_UNMAP, 32'h0, "unmapped_read");

    wr(A_PRESC, 32'h0);
    wr(A_CMP,   32'h5);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_STAT,  32'h1);
    wr(A_CTRL,  32'h7);
    rd(A_COUNT, 32'hFFFF_FFFF, "wrap_pre");
    rd(A_COUNT, 32'h0, "wrap_to_zero");
    rd(A_STAT,  32'h0, "wrap_no_match");
    rd(A_COUNT, 32'h2, "run_c2");
    rd(A_COUNT, 32'h3, "run_c3");
    rd(A_COUNT, 32'h4, "run_c4");
    rd(A_COUNT, 32'h5, "run_c5");
    chk("run_irq", {31'b0, irq}, 32'h1);
    rd(A_COUNT, 32'h0, "run_reload");

    reset = 1'b0;
    #1;
    chk("async_reset_irq", {31'b0, irq}, 32'h0);
    chk("async_reset_gpio_out", gpio_out, 32'h0);
    rd(A_CTRL,     32'h0, "async_reset_ctrl");
    rd(A_PRESC,    32'h0, "async_reset_presc");
    rd(A_COUNT,    32'h0, "async_reset_count");
    rd(A_CMP,      32'h0, "async_reset_cmp");
    rd(A_STAT,     32'h0, "async_reset_stat");
    rd(A_GPIO_OUT, 32'h0, "async_reset_gpio_out_reg");
    rd(A_GPIO_IN,  32'h0, "async_reset_gpio_in");
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
